mem_req_arbiter: RTL
====================

# mem_req_arbiter

Arbitrates the single byte-serial memory controller request port between the load/store buffer (LSB), the instruction cache and an optional instruction prefetcher. Sits between those requesters and the memory controller. Holds one transaction in flight at a time and routes the one-cycle completion pulse back to the granted requester. Applies fixed priority with anti-starvation for instruction fetch, and squashes stale fetch/load completions on pipeline flush.

## Interface
- STARVE_LIMIT, 4: consecutive LSB grants tolerated while ICache waits; range 1..7.
- clk_in  in  1  system clock
- rst_n_in  in  1  asynchronous, active-low reset
- rdy_in  in  1  global enable; when low, all state and outputs hold
- flush_in  in  1  pipeline flush pulse
- lsb_req_in  in  1  LSB request, level, held until lsb_valid_out
- lsb_is_store_in  in  1  0 = load, 1 = store
- lsb_op_in  in  6  load/store opcode (Lb/Lbu/Lh/Lhu/Lw/Sb/Sh/Sw)
- lsb_addr_in  in  32  byte address
- lsb_wdata_in  in  32  store data
- lsb_valid_out  out  1  one-cycle completion pulse
- lsb_rdata_out  out  32  load data, valid with lsb_valid_out
- ic_req_in  in  1  ICache fetch request, level
- ic_addr_in  in  32  fetch address
- ic_valid_out  out  1  one-cycle completion pulse
- ic_inst_out  out  32  fetched word
- pf_req_in / pf_addr_in / pf_valid_out / pf_inst_out: same shape as the ic_* ports (PREFETCH_PORT_EN only)
- mc_req_out  out  1  request to memory controller, held until mc_valid_in
- mc_is_store_out  out  1  0 = load/fetch, 1 = store
- mc_is_fetch_out  out  1  1 = instruction fetch
- mc_op_out  out  6  opcode; Lw for fetches
- mc_addr_out  out  32  address
- mc_wdata_out  out  32  store data
- mc_valid_in  in  1  controller completion pulse
- mc_rdata_in  in  32  load/fetch data, valid with mc_valid_in

## Operation
- Reset: all outputs 0, state IDLE, grant NONE, starvation counter 0, squash flag 0.
- States:
  - IDLE: samples requests. Priority is LSB > ICache > prefetch, except when starve_cnt == STARVE_LIMIT and ic_req_in = 1; then ICache wins. On a grant, latch the request fields into mc_*_out, set mc_req_out = 1, and go to WAIT.
  - WAIT: hold the mc_* outputs stable. On mc_valid_in, drop mc_req_out, register mc_rdata_in into the granted requester's data output, pulse its valid (unless squashed), and go to COOL.
  - COOL: deassert all valids, clear squash, grant NONE, go to IDLE. New requests are not sampled in COOL.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, on each LSB grant made while ic_req_in = 1.
  - Clears on an ICache grant or whenever ic_req_in = 0 in IDLE.
- Flush:
  - flush_in in WAIT with grant ICache, prefetch, or LSB load sets squash. The transfer still completes downstream; no valid pulse is produced, and the data output is unchanged.
  - LSB stores are never squashed.
  - flush_in in IDLE or COOL has no effect.
  - flush_in coincident with mc_valid_in squashes that completion.
- The prefetch port is granted only when neither LSB nor ICache requests.

## Timing
- Grant latency: request sampled in IDLE at edge t; mc_req_out high after edge t.
- Response latency: mc_valid_in sampled at edge t; requester valid high for exactly one cycle after edge t; low again after edge t+1.
- Minimum gap between two transactions: 3 cycles (IDLE, WAIT ≥1 cycle, COOL).
- Requesters must hold request and fields stable until their valid pulse. The arbiter latches fields at grant and ignores later changes.
- rdy_in = 0 freezes everything, including a pending mc_valid_in. The controller is stalled by the same rdy_in.
- Asynchronous reset mid-WAIT abandons the transaction. The controller is reset by the same event.

## Configuration
- PREFETCH_PORT_EN:
  - Defined: third requester port present, lowest priority, squashed on flush like ICache.
  - Undefined: pf_* ports absent, grant encoding has no prefetch value, and logic reduces to two requesters.

## Structure
- Shared include (const.v): load/store opcode constants, arbiter state encoding (IDLE/WAIT/COOL), and grant encoding (NONE/LSB/IC/PF).
- One sub-module: mem_arb_starve_ctr. It holds the saturating counter and exports starved, with inputs lsb_grant, ic_grant, ic_req.

## Test plan
- Reset then lone ic_req_in, addr 0x100: mc_req_out high one cycle later with mc_op_out = Lw and mc_is_fetch_out = 1. After mc_valid_in with data 0x00500093: ic_valid_out pulses once with ic_inst_out = 0x00500093.
- lsb_req_in and ic_req_in asserted together (Sw, addr 0x20, data 0xDEADBEEF): LSB granted first; ICache granted on the next IDLE.
- STARVE_LIMIT = 4, LSB requesting continuously and ICache held: LSB gets 4 grants, the 5th grant goes to ICache, then LSB resumes.
- flush_in during WAIT of an Lw: no lsb_valid_out pulse, and the next request is granted normally. flush_in during WAIT of an Sb: lsb_valid_out still pulses.
- Toggle rdy_in low for 3 cycles inside WAIT while mc_valid_in is held: the response pulses only after rdy_in returns, and no duplicate pulse occurs.
- With PREFETCH_PORT_EN, pf_req_in alone: granted. With pf_req_in and ic_req_in together: ICache granted first.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types for the memory request arbiter: opcodes, FSM states, grant encoding.
// PREFETCH_PORT_EN adds the prefetch grant value.
package mem_req_arbiter_pkg;

  localparam logic [5:0] OP_LB  = 6'd0;
  localparam logic [5:0] OP_LBU = 6'd1;
  localparam logic [5:0] OP_LH  = 6'd2;
  localparam logic [5:0] OP_LHU = 6'd3;
  localparam logic [5:0] OP_LW  = 6'd4;
  localparam logic [5:0] OP_SB  = 6'd5;
  localparam logic [5:0] OP_SH  = 6'd6;
  localparam logic [5:0] OP_SW  = 6'd7;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_COOL} arb_state_e;

`ifdef PREFETCH_PORT_EN
  typedef enum logic [1:0] {GNT_NONE, GNT_LSB, GNT_IC, GNT_PF} grant_e;
`else
  typedef enum logic [1:0] {GNT_NONE, GNT_LSB, GNT_IC} grant_e;
`endif

  // Stores have architecturally committed by the time they issue, so a flush never drops them.
  function automatic logic is_squashable(grant_e g, logic is_store);
    return (g == GNT_LSB) ? !is_store : (g != GNT_NONE);
  endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Request/response bus between the arbiter (master) and the memory controller (slave).
interface mem_req_arbiter_if;
  logic        req;
  logic        is_store;
  logic        is_fetch;
  logic [5:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        valid;
  logic [31:0] rdata;

  modport master (output req, is_store, is_fetch, op, addr, wdata, input valid, rdata);
  modport slave  (input req, is_store, is_fetch, op, addr, wdata, output valid, rdata);
endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of LSB grants made while the ICache waits; starved forces an ICache grant.
module mem_arb_starve_ctr #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic rdy_in,
  input  logic lsb_grant,
  input  logic ic_grant,
  input  logic ic_req,
  output logic starved
);

  logic [2:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (rdy_in) begin
      if (ic_grant || !ic_req) begin
        cnt <= '0;
      end else if (lsb_grant && cnt != 3'(STARVE_LIMIT)) begin
        cnt <= cnt + 3'd1;
      end
    end
  end

  assign starved = (cnt == 3'(STARVE_LIMIT));

endmodule

// File: rtl/mem_req_arbiter.sv
// Single-outstanding arbiter for the memory controller port: LSB > ICache > prefetch with
// ICache anti-starvation and flush squashing. PREFETCH_PORT_EN adds the prefetch requester.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        flush_in,
  input  logic        lsb_req_in,
  input  logic        lsb_is_store_in,
  input  logic [5:0]  lsb_op_in,
  input  logic [31:0] lsb_addr_in,
  input  logic [31:0] lsb_wdata_in,
  output logic        lsb_valid_out,
  output logic [31:0] lsb_rdata_out,
  input  logic        ic_req_in,
  input  logic [31:0] ic_addr_in,
  output logic        ic_valid_out,
  output logic [31:0] ic_inst_out,
`ifdef PREFETCH_PORT_EN
  input  logic        pf_req_in,
  input  logic [31:0] pf_addr_in,
  output logic        pf_valid_out,
  output logic [31:0] pf_inst_out,
`endif
  mem_req_arbiter_if.master mc
);

  arb_state_e state;
  grant_e     grant;
  logic       squash;
  logic       starved;
  logic       lsb_win;
  logic       ic_win;
  logic       squash_now;
`ifdef PREFETCH_PORT_EN
  logic       pf_win;
`endif

  // Outside IDLE the ICache request is masked high so waiting never clears the count.
  mem_arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .rdy_in    (rdy_in),
    .lsb_grant (lsb_win),
    .ic_grant  (ic_win),
    .ic_req    (ic_req_in || (state != ST_IDLE)),
    .starved   (starved)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    lsb_win = 1'b0;
    ic_win  = 1'b0;
`ifdef PREFETCH_PORT_EN
    pf_win  = 1'b0;
`endif
    if (state == ST_IDLE) begin
      if (ic_req_in && (starved || !lsb_req_in)) begin
        ic_win = 1'b1;
      end else if (lsb_req_in) begin
        lsb_win = 1'b1;
`ifdef PREFETCH_PORT_EN
      end else if (pf_req_in) begin
        pf_win = 1'b1;
`endif
      end
    end
  end

  assign squash_now = flush_in && is_squashable(grant, mc.is_store);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= ST_IDLE;
      grant         <= GNT_NONE;
      squash        <= 1'b0;
      mc.req        <= 1'b0;
      mc.is_store   <= 1'b0;
      mc.is_fetch   <= 1'b0;
      mc.op         <= '0;
      mc.addr       <= '0;
      mc.wdata      <= '0;
      lsb_valid_out <= 1'b0;
      lsb_rdata_out <= '0;
      ic_valid_out  <= 1'b0;
      ic_inst_out   <= '0;
`ifdef PREFETCH_PORT_EN
      pf_valid_out  <= 1'b0;
      pf_inst_out   <= '0;
`endif
    end else if (rdy_in) begin
      unique case (state)
        ST_IDLE: begin
          if (lsb_win) begin
            grant       <= GNT_LSB;
            mc.req      <= 1'b1;
            mc.is_store <= lsb_is_store_in;
            mc.is_fetch <= 1'b0;
            mc.op       <= lsb_op_in;
            mc.addr     <= lsb_addr_in;
            mc.wdata    <= lsb_wdata_in;
            state       <= ST_WAIT;
          end else if (ic_win) begin
            grant       <= GNT_IC;
            mc.req      <= 1'b1;
            mc.is_store <= 1'b0;
            mc.is_fetch <= 1'b1;
            mc.op       <= OP_LW;
            mc.addr     <= ic_addr_in;
            mc.wdata    <= '0;
            state       <= ST_WAIT;
`ifdef PREFETCH_PORT_EN
          end else if (pf_win) begin
            grant       <= GNT_PF;
            mc.req      <= 1'b1;
            mc.is_store <= 1'b0;
            mc.is_fetch <= 1'b1;
            mc.op       <= OP_LW;
            mc.addr     <= pf_addr_in;
            mc.wdata    <= '0;
            state       <= ST_WAIT;
`endif
          end
        end
        ST_WAIT: begin
          if (mc.valid) begin
            mc.req <= 1'b0;
            state  <= ST_COOL;
            // A squashed completion is consumed silently; the requester's data is left as-is.
            if (!(squash || squash_now)) begin
              unique case (grant)
                GNT_LSB: begin
                  lsb_valid_out <= 1'b1;
                  lsb_rdata_out <= mc.rdata;
                end
                GNT_IC: begin
                  ic_valid_out <= 1'b1;
                  ic_inst_out  <= mc.rdata;
                end
`ifdef PREFETCH_PORT_EN
                GNT_PF: begin
                  pf_valid_out <= 1'b1;
                  pf_inst_out  <= mc.rdata;
                end
`endif
                default: ;
              endcase
            end
          end else if (squash_now) begin
            squash <= 1'b1;
          end
        end
        ST_COOL: begin
          lsb_valid_out <= 1'b0;
          ic_valid_out  <= 1'b0;
`ifdef PREFETCH_PORT_EN
          pf_valid_out  <= 1'b0;
`endif
          squash <= 1'b0;
          grant  <= GNT_NONE;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
